// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word load-store front end with read-modify-write for sub-word stores
module load_store_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            size,
  input  logic                  unsigned_ld,
  input  logic [31:0]           address,
  input  logic [31:0]           store_data,
  output logic [31:0]           load_data,
  output logic                  busy,
  output logic                  misaligned,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout
);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WRITE} state_t;
  state_t state, state_nx;
  logic [1:0]            lane, sz;
  logic                  uns;
  logic [15:0]           sdata;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [31:0]           ld_reg, shifted, ext, mask, merged;
  logic                  req, illegal;
  logic                  unused;
  assign unused  = ^{address[31:ADDR_WIDTH+2], store_data[31:16]};
  assign req     = mem_read | mem_write;
  assign illegal = (size == 2'b11) | (size == 2'b01 & address[0]) | (size == 2'b10 & |address[1:0]);
  // Lane extraction and lane merge; a halfword lane has lane[0]=0, so one byte-granular shift serves both sizes
  always_comb begin
    shifted = mem_dout >> {lane, 3'b000};
    ext     = sz == 2'b10 ? mem_dout :
              sz == 2'b01 ? {{16{~uns & shifted[15]}}, shifted[15:0]} :
                            {{24{~uns & shifted[7]}}, shifted[7:0]};
    mask    = (sz == 2'b01 ? 32'h0000_FFFF : 32'h0000_00FF) << {lane, 3'b000};
    merged  = (mem_dout & ~mask) | ((sz == 2'b01 ? {2{sdata}} : {4{sdata[7:0]}}) & mask);
  end
  // Next state and outputs; reset forces every strobe low combinationally
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    misaligned = 1'b0;
    mem_we     = 1'b0;
    mem_din    = 32'h0;
    mem_addr   = waddr;
    load_data  = ld_reg;
    case (state)
      IDLE: begin
        mem_addr = address[ADDR_WIDTH+1:2];
        if (req && illegal) misaligned = 1'b1;
        else if (mem_write && size == 2'b10) begin
          mem_we  = 1'b1;
          mem_din = store_data;
        end else if (req) begin
          busy     = 1'b1;
          state_nx = mem_write ? RMW_WRITE : LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        load_data = ext;
        state_nx  = IDLE;
      end
      RMW_WRITE: begin
        mem_we   = 1'b1;
        mem_din  = merged;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (reset) begin
      busy       = 1'b0;
      misaligned = 1'b0;
      mem_we     = 1'b0;
      mem_din    = 32'h0;
      load_data  = 32'h0;
      state_nx   = IDLE;
    end
  end
  // State register, request capture on acceptance, and load result hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      lane   <= 2'b00;
      sz     <= 2'b00;
      uns    <= 1'b0;
      sdata  <= 16'h0;
      waddr  <= '0;
      ld_reg <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE) begin
        lane  <= address[1:0];
        sz    <= size;
        uns   <= unsigned_ld;
        sdata <= store_data[15:0];
        waddr <= address[ADDR_WIDTH+1:2];
      end
      if (state == LOAD_WAIT) ld_reg <= ext;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit against a synchronous-read memory
module tb_load_store_unit;
  logic        clk = 1'b0, reset = 1'b1, mem_read = 1'b0, mem_write = 1'b0, unsigned_ld = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] address = 32'h0, store_data = 32'h0, mem_dout = 32'h0;
  logic [31:0] load_data, mem_din;
  logic        busy, misaligned, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem [0:1023];
  int n_cmp = 0, n_err = 0;

  load_store_unit #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .size(size),
    .unsigned_ld(unsigned_ld), .address(address), .store_data(store_data), .load_data(load_data),
    .busy(busy), .misaligned(misaligned), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Data memory: one-cycle read latency, write on enable
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] sd);
    @(negedge clk);
    mem_read = rd; mem_write = wr; size = sz; unsigned_ld = uns; address = a; store_data = sd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899_AABB;
    mem[1] = 32'h1122_3344;
    mem[8] = 32'hCAFE_F00D;
    // reset holds strobes low even with an aligned word store presented
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ld", load_data, 32'h0);
    chk("rst_din", mem_din, 32'h0);
    drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    chk("rst_mis", misaligned, 0);
    idle();
    reset = 1'b0;
    // signed byte load of 0x13
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("b_busy", busy, 1);
    chk("b_addr", mem_addr, 4);
    chk("b_we", mem_we, 0);
    idle();
    chk("b_busy2", busy, 0);
    chk("b_ld", load_data, 32'hFFFF_FF88);
    idle();
    chk("b_hold", load_data, 32'hFFFF_FF88);
    // unsigned halfword load of 0x12
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    chk("c_busy", busy, 1);
    idle();
    chk("c_ld", load_data, 32'h0000_8899);
    // unsigned byte load with high address bits set, lane 0
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'hFFFF_F010, 32'h0);
    chk("d_addr", mem_addr, 4);
    idle();
    chk("d_ld", load_data, 32'h0000_00BB);
    // byte store of 0x5A at 0x11 via read-modify-write
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_565A);
    chk("e_busy", busy, 1);
    chk("e_we", mem_we, 0);
    chk("e_addr", mem_addr, 4);
    idle();
    chk("e_we2", mem_we, 1);
    chk("e_din", mem_din, 32'h8899_5ABB);
    chk("e_busy2", busy, 0);
    chk("e_ld", load_data, 32'h0000_00BB);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    idle();
    chk("e_ld2", load_data, 32'h8899_5ABB);
    // misaligned and illegal accesses
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFF_FFFF);
    chk("f_mis", misaligned, 1);
    chk("f_we", mem_we, 0);
    chk("f_busy", busy, 0);
    chk("f_ld", load_data, 32'h8899_5ABB);
    idle();
    chk("f_mis2", misaligned, 0);
    chk("f_we2", mem_we, 0);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
    chk("f_mis3", misaligned, 1);
    chk("f_busy3", busy, 0);
    drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    chk("f_mis4", misaligned, 1);
    idle();
    chk("f_mem", mem[8], 32'hCAFE_F00D);
    chk("f_ld2", load_data, 32'h8899_5ABB);
    // halfword store into upper lane, then signed halfword load back
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h06, 32'h0000_BEEF);
    chk("g_busy", busy, 1);
    idle();
    chk("g_we", mem_we, 1);
    chk("g_din", mem_din, 32'hBEEF_3344);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h06, 32'h0);
    idle();
    chk("g_ld", load_data, 32'hFFFF_BEEF);
    // reset pulsed during the write half of a halfword store
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h04, 32'h0000_7777);
    chk("h_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1; mem_write = 1'b0;
    #1;
    chk("h_we", mem_we, 0);
    chk("h_busy2", busy, 0);
    chk("h_ld", load_data, 32'h0);
    idle();
    reset = 1'b0;
    idle();
    chk("h_mem", mem[1], 32'hBEEF_3344);
    chk("h_we2", mem_we, 0);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    chk("h_busy3", busy, 1);
    idle();
    chk("h_ld2", load_data, 32'hBEEF_3344);
    // simultaneous read and write resolves to a one-cycle word store
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h04, 32'h0102_0304);
    chk("i_we", mem_we, 1);
    chk("i_din", mem_din, 32'h0102_0304);
    chk("i_busy", busy, 0);
    chk("i_addr", mem_addr, 1);
    chk("i_ld", load_data, 32'hBEEF_3344);
    idle();
    chk("i_we2", mem_we, 0);
    chk("i_busy2", busy, 0);
    chk("i_ld2", load_data, 32'hBEEF_3344);
    chk("i_mem", mem[1], 32'h0102_0304);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
